// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one CPU-style memory port (request fields plus resp/rdata)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  localparam int MASK_W = DATA_W / 8;
  logic              read;
  logic              write;
  logic [MASK_W-1:0] wmask;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              resp;
  logic [DATA_W-1:0] rdata;
  modport master (output read, write, wmask, address, wdata, input resp, rdata);
  modport slave  (input read, write, wmask, address, wdata, output resp, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU ports a (ifetch) and b (data) onto one physical memory port.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed b-over-a priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  port_a,
  mem_port_arbiter_if.slave  port_b,
  mem_port_arbiter_if.master pmem
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t            r_state;
  logic              r_sel_b;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_addr;
  logic [MASK_W-1:0] r_wmask;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic              r_resp_a;
  logic              r_resp_b;
  logic              w_req_a;
  logic              w_req_b;
  logic              w_sel_b;
  logic              w_write;
  logic [ADDR_W-1:0] w_addr;
  logic [MASK_W-1:0] w_wmask;
  logic [DATA_W-1:0] w_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              r_last_b;
  // tie goes to the port that did not win last time
  always_comb begin
    w_req_a = port_a.read | port_a.write;
    w_req_b = port_b.read | port_b.write;
    w_sel_b = w_req_b & (~w_req_a | ~r_last_b);
  end
  // remember the most recent grant; starts as if a had been served
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last_b <= 1'b0;
    else if (r_state == IDLE && (w_req_a || w_req_b)) r_last_b <= w_sel_b;
`else
  // fixed priority: b wins whenever it requests
  always_comb begin
    w_req_a = port_a.read | port_a.write;
    w_req_b = port_b.read | port_b.write;
    w_sel_b = w_req_b;
  end
`endif
  // winner's request fields; read+write together is treated as a write
  always_comb begin
    w_write = w_sel_b ? port_b.write   : port_a.write;
    w_addr  = w_sel_b ? port_b.address : port_a.address;
    w_wmask = w_sel_b ? port_b.wmask   : port_a.wmask;
    w_wdata = w_sel_b ? port_b.wdata   : port_a.wdata;
  end
  // grant/latch in IDLE, hold pmem until resp in BUSY, pulse resp for one cycle in RESP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel_b      <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_addr       <= '0;
      r_wmask      <= '0;
      r_wdata      <= '0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_resp_a     <= 1'b0;
      r_resp_b     <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (w_req_a || w_req_b) begin
            r_sel_b      <= w_sel_b;
            r_pmem_read  <= ~w_write;
            r_pmem_write <= w_write;
            r_addr       <= w_addr;
            r_wmask      <= w_wmask;
            r_wdata      <= w_wdata;
            r_state      <= BUSY;
          end
        BUSY:
          if (pmem.resp) begin
            if (r_pmem_read && r_sel_b) r_rdata_b <= pmem.rdata;
            if (r_pmem_read && !r_sel_b) r_rdata_a <= pmem.rdata;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_resp_a     <= ~r_sel_b;
            r_resp_b     <= r_sel_b;
            r_state      <= RESP;
          end
        RESP: begin
          r_resp_a <= 1'b0;
          r_resp_b <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign pmem.read     = r_pmem_read;
  assign pmem.write    = r_pmem_write;
  assign pmem.address  = r_addr;
  assign pmem.wmask    = r_wmask;
  assign pmem.wdata    = r_wdata;
  assign port_a.resp   = r_resp_a;
  assign port_a.rdata  = r_rdata_a;
  assign port_b.resp   = r_resp_b;
  assign port_b.rdata  = r_rdata_b;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_b;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) a_if ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b_if ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) pm_if ();
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .port_a(a_if), .port_b(b_if), .pmem(pm_if)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    a_if.read = 0; a_if.write = 0; a_if.wmask = 0; a_if.address = 0; a_if.wdata = 0;
    b_if.read = 0; b_if.write = 0; b_if.wmask = 0; b_if.address = 0; b_if.wdata = 0;
    pm_if.resp = 0; pm_if.rdata = 0;
    tick(); tick();
    chk("rst pmem_read", pm_if.read, 0);
    chk("rst pmem_write", pm_if.write, 0);
    chk("rst pmem_address", pm_if.address, 0);
    chk("rst rdata_a", a_if.rdata, 0);
    chk("rst rdata_b", b_if.rdata, 0);
    rst_n = 1'b1;
    tick();
    // a read 0x1000, memory answers in the first cycle
    a_if.read = 1; a_if.address = 16'h1000;
    tick();
    chk("t1 pmem_read", pm_if.read, 1);
    chk("t1 pmem_write", pm_if.write, 0);
    chk("t1 pmem_address", pm_if.address, 16'h1000);
    pm_if.resp = 1; pm_if.rdata = 16'h1234;
    tick();
    chk("t1 resp_a", a_if.resp, 1);
    chk("t1 resp_b", b_if.resp, 0);
    chk("t1 rdata_a", a_if.rdata, 16'h1234);
    chk("t1 pmem_read off", pm_if.read, 0);
    pm_if.resp = 0; a_if.read = 0;
    tick();
    chk("t1 resp_a pulse", a_if.resp, 0);
    // simultaneous reads: b first, then a
    a_if.read = 1; a_if.address = 16'h0100;
    b_if.read = 1; b_if.address = 16'h0200;
    tick();
    chk("t3 first addr", pm_if.address, 16'h0200);
    pm_if.resp = 1; pm_if.rdata = 16'hAAAA;
    tick();
    chk("t3 resp_b", b_if.resp, 1);
    chk("t3 resp_a idle", a_if.resp, 0);
    chk("t3 rdata_b", b_if.rdata, 16'hAAAA);
    pm_if.resp = 0; b_if.read = 0;
    tick();
    chk("t3 gap pmem_read", pm_if.read, 0);
    chk("t3 gap resp_b", b_if.resp, 0);
    tick();
    chk("t3 second read", pm_if.read, 1);
    chk("t3 second addr", pm_if.address, 16'h0100);
    pm_if.resp = 1; pm_if.rdata = 16'h5555;
    tick();
    chk("t3 resp_a", a_if.resp, 1);
    chk("t3 resp_b off", b_if.resp, 0);
    chk("t3 rdata_a", a_if.rdata, 16'h5555);
    chk("t3 rdata_b hold", b_if.rdata, 16'hAAAA);
    pm_if.resp = 0; a_if.read = 0;
    tick();
    // b write, memory answers after 3 cycles
    b_if.write = 1; b_if.address = 16'h2002; b_if.wdata = 16'hBEEF; b_if.wmask = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2 pmem_write", pm_if.write, 1);
      chk("t2 pmem_read", pm_if.read, 0);
      chk("t2 pmem_wmask", pm_if.wmask, 2'b10);
      chk("t2 pmem_wdata", pm_if.wdata, 16'hBEEF);
      chk("t2 pmem_address", pm_if.address, 16'h2002);
      chk("t2 early resp_b", b_if.resp, 0);
      if (i == 2) pm_if.resp = 1;
    end
    pm_if.rdata = 16'h7777;
    tick();
    chk("t2 resp_b", b_if.resp, 1);
    chk("t2 resp_a", a_if.resp, 0);
    chk("t2 rdata_b unchanged", b_if.rdata, 16'hAAAA);
    pm_if.resp = 0; b_if.write = 0;
    tick();
    chk("t2 resp_b pulse", b_if.resp, 0);
    // address change after latch is ignored
    a_if.read = 1; a_if.address = 16'h1000;
    tick();
    a_if.address = 16'h3000;
    tick();
    chk("t5 addr held", pm_if.address, 16'h1000);
    pm_if.resp = 1; pm_if.rdata = 16'h4321;
    tick();
    chk("t5 resp_a", a_if.resp, 1);
    chk("t5 rdata_a", a_if.rdata, 16'h4321);
    pm_if.resp = 0; a_if.read = 0;
    tick();
    // reset during BUSY
    a_if.read = 1; a_if.address = 16'h1000;
    tick();
    chk("t6 busy pmem_read", pm_if.read, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 pmem_read drop", pm_if.read, 0);
    chk("t6 pmem_address", pm_if.address, 0);
    chk("t6 rdata_a", a_if.rdata, 0);
    chk("t6 resp_a", a_if.resp, 0);
    a_if.read = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6 no resp", a_if.resp, 0);
    a_if.read = 1; a_if.address = 16'h0042;
    tick();
    chk("t6 new read", pm_if.read, 1);
    chk("t6 new addr", pm_if.address, 16'h0042);
    pm_if.resp = 1; pm_if.rdata = 16'h9999;
    tick();
    chk("t6 new resp_a", a_if.resp, 1);
    chk("t6 new rdata_a", a_if.rdata, 16'h9999);
    pm_if.resp = 0; a_if.read = 0;
    tick();
    // both ports keep requesting for four grants
    a_if.read = 1; a_if.address = 16'h0100;
    b_if.read = 1; b_if.address = 16'h0200;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_b = (k % 2 == 0);
`else
      exp_b = 1'b1;
`endif
      tick();
      chk("t4 grant addr", pm_if.address, exp_b ? 16'h0200 : 16'h0100);
      pm_if.resp = 1; pm_if.rdata = 16'h0F00 + 16'(k);
      tick();
      chk("t4 resp_b", b_if.resp, exp_b);
      chk("t4 resp_a", a_if.resp, !exp_b);
      pm_if.resp = 0;
      tick();
    end
    a_if.read = 0; b_if.read = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
